// File: rtl/dma_arbiter.sv
// Multi-channel DMA burst arbiter in front of a single-port memory.
// Round-robin by default; define DMA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module dma_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int NUM_CH     = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  ch_len,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_wready,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]            ch_done,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [CH_W-1:0]       cur_r, cur_nxt_s, ptr_r, ptr_nxt_s, win_s;
    logic [ADDR_WIDTH-1:0] base_r, base_nxt_s;
    logic [LEN_WIDTH-1:0]  len_r, len_nxt_s, beat_r, beat_nxt_s;
    logic                  we_r, we_nxt_s;
    logic [NUM_CH-1:0]     gnt_r, wready_r, rvalid_r, done_r;
    logic                  mem_en_r, mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = (idx == CH_W'(i));
        end
        return v;
    endfunction

`ifdef DMA_ARB_FIXED_PRIO_EN
    // Fixed-priority winner select: descending scan leaves the lowest requester.
    always_comb begin
        win_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                win_s = CH_W'(i);
            end else begin
                win_s = win_s;
            end
        end
    end
`else
    int rr_idx_s;

    // Round-robin winner select: scan offsets from the pointer, nearest requester wins.
    always_comb begin
        win_s    = '0;
        rr_idx_s = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            rr_idx_s = int'(ptr_r) + i;
            if (rr_idx_s >= NUM_CH) begin
                rr_idx_s = rr_idx_s - NUM_CH;
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (ch_req[rr_idx_s]) begin
                win_s = CH_W'(rr_idx_s);
            end else begin
                win_s = win_s;
            end
        end
    end
`endif

    // Burst FSM next-state and working-register updates.
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        ptr_nxt_s   = ptr_r;
        base_nxt_s  = base_r;
        len_nxt_s   = len_r;
        we_nxt_s    = we_r;
        beat_nxt_s  = beat_r;
        case (state_r)
            IDLE: begin
                if (|ch_req) begin
                    cur_nxt_s  = win_s;
                    base_nxt_s = ch_addr[int'(win_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    len_nxt_s  = ch_len[int'(win_s)*LEN_WIDTH +: LEN_WIDTH];
                    we_nxt_s   = ch_we[win_s];
                    beat_nxt_s = '0;
                    ptr_nxt_s  = (win_s == CH_W'(NUM_CH - 1)) ? '0 : win_s + CH_W'(1);
                    if (len_nxt_s == '0) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = XFER;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                if (beat_r == len_r - LEN_WIDTH'(1)) begin
                    state_nxt_s = we_r ? DONE : DRAIN;
                end else begin
                    beat_nxt_s = beat_r + LEN_WIDTH'(1);
                end
            end
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, working registers and registered outputs aligned to the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cur_r      <= '0;
            ptr_r      <= '0;
            base_r     <= '0;
            len_r      <= '0;
            we_r       <= 1'b0;
            beat_r     <= '0;
            gnt_r      <= '0;
            wready_r   <= '0;
            rvalid_r   <= '0;
            done_r     <= '0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cur_r      <= cur_nxt_s;
            ptr_r      <= ptr_nxt_s;
            base_r     <= base_nxt_s;
            len_r      <= len_nxt_s;
            we_r       <= we_nxt_s;
            beat_r     <= beat_nxt_s;
            gnt_r      <= (state_nxt_s == XFER || state_nxt_s == DRAIN) ? onehot(cur_nxt_s) : '0;
            wready_r   <= (state_nxt_s == XFER && we_nxt_s) ? onehot(cur_nxt_s) : '0;
            done_r     <= (state_nxt_s == DONE) ? onehot(cur_nxt_s) : '0;
            mem_en_r   <= (state_nxt_s == XFER);
            mem_we_r   <= (state_nxt_s == XFER) && we_nxt_s;
            mem_addr_r <= (state_nxt_s == XFER) ? base_nxt_s + ADDR_WIDTH'(beat_nxt_s) : '0;
            // Memory answers one cycle after a read strobe; flag it for the owning channel.
            rvalid_r   <= (mem_en_r && !mem_we_r) ? gnt_r : '0;
        end
    end

    assign ch_gnt    = gnt_r;
    assign ch_wready = wready_r;
    assign ch_rvalid = rvalid_r;
    assign ch_done   = done_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    // Write data passes straight through so the channel can advance right after wready.
    assign mem_wdata = (mem_en_r && mem_we_r) ? ch_wdata[int'(cur_r)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ch_rdata  = (|rvalid_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed self-checking bench for dma_arbiter (2 channels, default widths).
// Honours DMA_ARB_FIXED_PRIO_EN for the arbitration-order expectation.
module tb_dma_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_req, ch_we, ch_gnt, ch_wready, ch_rvalid, ch_done;
    logic [39:0] ch_addr;
    logic [15:0] ch_len;
    logic [31:0] ch_wdata;
    logic [15:0] ch_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic [19:0] mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    dma_arbiter dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .ch_wready(ch_wready),
        .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .ch_done(ch_done), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read returns the low address bits one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[15:0];
        else                   mem_rdata <= 16'h0000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        logic [19:0] ea;
        logic [1:0]  exp_done;
        logic        got;

        reset = 1'b0; ch_req = 2'b00; ch_we = 2'b00; ch_addr = 40'h0;
        ch_len = 16'h0; ch_wdata = 32'h0;
        #2;
        chk("reset_gnt", ch_gnt, 2'b00);
        chk("reset_mem_en", mem_en, 1'b0);
        chk("reset_done", ch_done, 2'b00);
        tick(); tick();
        reset = 1'b1;
        tick();

        // ch0 read, base 0x10, len 4
        ch_req = 2'b01; ch_we = 2'b00; ch_addr[19:0] = 20'h00010; ch_len[7:0] = 8'd4;
        tick();
        chk("rd_gnt", ch_gnt, 2'b01);
        chk("rd_mem_en", mem_en, 1'b1);
        chk("rd_mem_we", mem_we, 1'b0);
        chk("rd_addr0", mem_addr, 20'h00010);
        chk("rd_rvalid0", ch_rvalid, 2'b00);
        ch_req = 2'b00; ch_addr[19:0] = 20'h55555; ch_len[7:0] = 8'd9;
        for (int b = 1; b < 4; b++) begin
            tick();
            chk("rd_addr", mem_addr, 32'h10 + b);
            chk("rd_rvalid", ch_rvalid, 2'b01);
            chk("rd_rdata", ch_rdata, 32'h10 + b - 1);
        end
        tick();
        chk("drain_mem_en", mem_en, 1'b0);
        chk("drain_rvalid", ch_rvalid, 2'b01);
        chk("drain_rdata", ch_rdata, 16'h0013);
        chk("drain_gnt", ch_gnt, 2'b01);
        tick();
        chk("rd_done", ch_done, 2'b01);
        chk("rd_done_gnt", ch_gnt, 2'b00);
        chk("rd_done_rvalid", ch_rvalid, 2'b00);
        tick();
        chk("rd_done_once", ch_done, 2'b00);

        // ch1 write across the address wrap
        ch_req = 2'b10; ch_we = 2'b10; ch_addr[39:20] = 20'hFFFFE; ch_len[15:8] = 8'd3;
        ch_wdata[31:16] = 16'h00A1;
        for (int b = 0; b < 3; b++) begin
            tick();
            ea = 20'hFFFFE + 20'(b);
            chk("wr_gnt", ch_gnt, 2'b10);
            chk("wr_mem_we", mem_we, 1'b1);
            chk("wr_addr", mem_addr, ea);
            chk("wr_wdata", mem_wdata, 32'hA1 + b);
            chk("wr_wready", ch_wready, 2'b10);
            ch_req = 2'b00;
            ch_wdata[31:16] = 16'(16'h00A1 + 16'(b + 1));
        end
        tick();
        chk("wr_done", ch_done, 2'b10);
        chk("wr_done_mem_en", mem_en, 1'b0);
        chk("wr_done_wready", ch_wready, 2'b00);
        tick();

        // Both channels hold requests, len 2 reads
        ch_we = 2'b00; ch_len = {8'd2, 8'd2}; ch_addr = {20'h00200, 20'h00300};
        ch_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
            exp_done = 2'b01;
`else
            exp_done = k[0] ? 2'b10 : 2'b01;
`endif
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                chk("arb_onehot", 32'($countones(ch_gnt) <= 1), 1);
                if (ch_done != 2'b00) got = 1'b1;
            end
            chk("arb_done_seen", got, 1'b1);
            chk("arb_order", ch_done, exp_done);
        end
        ch_req = 2'b00;
        tick(); tick();

        // Zero-length burst on ch0
        ch_req = 2'b01; ch_len[7:0] = 8'd0;
        tick();
        chk("len0_done", ch_done, 2'b01);
        chk("len0_mem_en", mem_en, 1'b0);
        chk("len0_gnt", ch_gnt, 2'b00);
        ch_req = 2'b00;
        tick();
        chk("len0_done_once", ch_done, 2'b00);
        chk("len0_mem_en2", mem_en, 1'b0);

        // Reset in the middle of a len-8 read
        ch_req = 2'b01; ch_addr[19:0] = 20'h00100; ch_len[7:0] = 8'd8;
        tick();
        ch_req = 2'b00;
        tick(); tick();
        chk("abort_beat2_addr", mem_addr, 20'h00102);
        reset = 1'b0;
        #1;
        chk("abort_gnt", ch_gnt, 2'b00);
        chk("abort_mem_en", mem_en, 1'b0);
        chk("abort_mem_addr", mem_addr, 20'h00000);
        chk("abort_rvalid", ch_rvalid, 2'b00);
        chk("abort_rdata", ch_rdata, 16'h0000);
        chk("abort_misc", {ch_done, ch_wready, mem_we, mem_wdata}, 21'h0);
        tick();
        chk("abort_no_done", ch_done, 2'b00);
        reset = 1'b1;
        ch_req = 2'b11; ch_len = {8'd1, 8'd1}; ch_addr[19:0] = 20'h00100;
        tick();
        chk("post_reset_gnt", ch_gnt, 2'b01);
        chk("post_reset_addr", mem_addr, 20'h00100);
        ch_req = 2'b00;
        tick(); tick();
        chk("post_reset_done", ch_done, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
